det_sequencer: RTL and testbench
================================

# det_sequencer

Sequencing controller for the matrix determinant datapath. It accepts a determinant request with a matrix size, then collects the int8 elements one per handshake in row-major order. It packs them into the 200-bit matrix bus and holds bus and size stable for a fixed settle latency. It then captures the 8-bit determinant and returns it over a valid/ready handshake, letting a byte-serial bus or CPU front end drive the wide combinational/clocked determinant unit.

## Interface
- `DET_LATENCY`, default 4: cycles the matrix and size are held stable before the result is sampled; legal range 1–255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request strobe, accepted when `start_ready`=1.
- `size` input 8: matrix order (2..5), sampled with `start`.
- `start_ready` output 1: high only in IDLE.
- `in_data` input 8: signed element, row-major.
- `in_valid` input 1: element valid.
- `in_ready` output 1: high only in LOAD.
- `abort` input 1: synchronous cancel, highest priority after reset.
- `det_matrix` output 200: packed matrix to datapath; element k at bits [k*8 +: 8].
- `det_size` output 8: size to datapath.
- `det_result` input 8: determinant from datapath.
- `result` output 8: captured determinant.
- `result_valid` output 1: result available.
- `result_ready` input 1: consumer accepts result.
- `error` output 1: request rejected (see Configuration).
- `busy` output 1: high in any state other than IDLE.

## Operation
- States are IDLE, LOAD, WAIT, DONE. Reset value of every output is 0, except `start_ready`=1.
- IDLE:
  - On `start`, latch n=`size` into `det_size`, clear `det_matrix` to 0, clear element counter k=0 and clear `error`.
  - Go to LOAD, or to DONE if the size is rejected.
- LOAD:
  - `in_ready`=1. Each `in_valid`&&`in_ready` writes `in_data` to `det_matrix[k*8 +: 8]` and increments k.
  - The transfer with k=n*n−1 goes to WAIT. Bytes beyond n*n are never accepted; unused upper bytes stay 0.
- WAIT:
  - The wait counter is loaded with DET_LATENCY−1 on entry and decrements each cycle.
  - At count 0, `result` is taken from `det_result` on that edge and the state goes to DONE.
  - `det_matrix` and `det_size` are constant throughout WAIT and DONE.
- DONE:
  - `result_valid`=1, and `result`/`error` are held stable until `result_ready`.
  - `result_valid`&&`result_ready` returns to IDLE next cycle. `det_matrix` and `det_size` keep their values until the next accepted `start`.
- `abort` in any state returns to IDLE next cycle and clears k, `det_matrix`, `det_size`, `result`, `result_valid` and `error`. Abort wins over a simultaneous transfer or `start`.
- `start` outside IDLE is ignored (not queued).
- Result width is 8 bits. Signed interpretation and saturation are the datapath's responsibility; the sequencer passes bits through unmodified.

## Timing
- With `start` accepted at cycle T, `in_ready` is high from T+1.
- With no stalls, the last element is at T+n². `result_valid` rises at T+n²+DET_LATENCY+1.
- `in_valid` gaps stretch LOAD by one cycle per idle cycle; there is no timeout.
- The minimum gap between a result handshake and the next accepted `start` is 1 cycle, since `start_ready` rises the cycle after consumption.
- Reset is asynchronous and takes effect mid-operation with no completion. After `rst_n` deasserts, the first `start` is accepted on the first rising edge.

## Configuration
- `DET_SEQ_SIZE_CHECK_EN` defined:
  - A `size` outside 2..5 at `start` goes IDLE→DONE directly with `error`=1 and `result`=0.
  - No elements are requested and `det_size` is latched as 0.
  - `result_valid` rises at T+1.
- Not defined:
  - `size` is clamped: values <2 are treated as 2, values >5 as 5. The clamped value drives both `det_size` and n.
  - `error` is tied to 0.

## Test plan
- 2×2 {3,4,2,5}, DET_LATENCY=4, `start` at T, no stalls → `det_matrix[31:0]`=0x05020403, `result`=0x07, `result_valid` at T+9.
- 2×2 {1,2,3,4} with `in_valid` low for 3 cycles after the 2nd byte, `result_ready` low for 10 cycles → `result`=0xFE held stable all 10 cycles; `result_valid` at T+12; IDLE one cycle after the handshake.
- 3×3 diag {2,0,0,0,3,0,0,0,4} → `result`=24 (0x18); exactly 9 `in_ready` handshakes; `det_matrix[199:72]`=0.
- 5×5 identity with `start` pulsed again during LOAD → second `start` ignored; 25 elements accepted; `result`=1.
- `abort` after 2 of 4 elements, then a new 2×2 {3,4,2,5} request → `det_matrix`=0 and `start_ready`=1 one cycle after abort; new result=0x07.
- `size`=6: with `DET_SEQ_SIZE_CHECK_EN` → `error`=1, `result`=0, `result_valid` at T+1, no `in_ready`. Without it → treated as 5, 25 elements requested, `error`=0. `rst_n` pulsed low during WAIT → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/det_sequencer_if.sv
// ---------------------------------------------------------------------------
// det_sequencer_if
// Bundles the request, element-load, datapath and result handshakes of the
// determinant sequencer.
//   master : front end plus determinant datapath (drives start/size, elements,
//            abort, det_result, result_ready)
//   slave  : det_sequencer (drives ready flags, packed matrix, size, result,
//            result_valid, error, busy)
// ---------------------------------------------------------------------------
interface det_sequencer_if;
    logic         start;
    logic [7:0]   size;
    logic         start_ready;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         abort;
    logic [199:0] det_matrix;
    logic [7:0]   det_size;
    logic [7:0]   det_result;
    logic [7:0]   result;
    logic         result_valid;
    logic         result_ready;
    logic         error;
    logic         busy;

    modport master (
        output start, size, in_data, in_valid, abort, det_result, result_ready,
        input  start_ready, in_ready, det_matrix, det_size, result, result_valid,
               error, busy
    );

    modport slave (
        input  start, size, in_data, in_valid, abort, det_result, result_ready,
        output start_ready, in_ready, det_matrix, det_size, result, result_valid,
               error, busy
    );
endinterface

// File: rtl/det_sequencer.sv
// ---------------------------------------------------------------------------
// det_sequencer
// Byte-serial front end for the matrix determinant datapath. A request
// latches the matrix order, the int8 elements are collected row-major into a
// 200-bit bus, bus and size are held for DET_LATENCY cycles, then the 8-bit
// determinant is captured and offered on a valid/ready handshake.
//
// Parameters:
//   DET_LATENCY : settle cycles before det_result is sampled (1..255)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : det_sequencer_if.slave (start/size, in_data/in_valid/in_ready,
//           abort, det_matrix/det_size/det_result, result/result_valid/
//           result_ready, error, busy)
// Build option:
//   DET_SEQ_SIZE_CHECK_EN : reject sizes outside 2..5 with error=1 instead of
//                           clamping them into range.
// ---------------------------------------------------------------------------
module det_sequencer #(
    parameter int unsigned DET_LATENCY = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    det_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [7:0] WAIT_INIT = 8'(DET_LATENCY - 32'd1);

    state_e         state_q, state_d;
    logic [4:0]     k_q, k_d;
    logic [7:0]     wait_q, wait_d;
    logic [199:0]   matrix_q, matrix_d;
    logic [7:0]     size_q, size_d;
    logic [7:0]     result_q, result_d;
    logic           error_q, error_d;
    logic           result_valid_q, result_valid_d;
    logic           start_ready_q, start_ready_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;

    logic           size_ok_s;
    logic [7:0]     size_eff_s;
    logic [5:0]     nsq_s;
    logic [4:0]     last_k_s;
    logic           load_fire_s;

`ifdef DET_SEQ_SIZE_CHECK_EN
    // Out-of-range orders are rejected outright.
    assign size_ok_s  = (bus.size >= 8'd2) && (bus.size <= 8'd5);
    assign size_eff_s = bus.size;
`else
    // Out-of-range orders are clamped into 2..5 and always accepted.
    assign size_ok_s  = 1'b1;
    assign size_eff_s = (bus.size < 8'd2) ? 8'd2 :
                        ((bus.size > 8'd5) ? 8'd5 : bus.size);
`endif

    // Only the low 3 bits matter while loading: the latched order is 2..5.
    assign nsq_s       = {3'b000, size_q[2:0]} * {3'b000, size_q[2:0]};
    assign last_k_s    = 5'(nsq_s - 6'd1);
    assign load_fire_s = in_ready_q && bus.in_valid;

    // Next-state and datapath-register update; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wait_d   = wait_q;
        matrix_d = matrix_q;
        size_d   = size_q;
        result_d = result_q;
        error_d  = error_q;

        if (bus.abort) begin
            state_d  = S_IDLE;
            k_d      = 5'd0;
            wait_d   = 8'd0;
            matrix_d = '0;
            size_d   = 8'd0;
            result_d = 8'd0;
            error_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        matrix_d = '0;
                        k_d      = 5'd0;
                        result_d = 8'd0;
                        if (size_ok_s) begin
                            size_d  = size_eff_s;
                            error_d = 1'b0;
                            state_d = S_LOAD;
                        end else begin
                            // Rejected request: report straight away, nothing loaded.
                            size_d  = 8'd0;
                            error_d = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (load_fire_s) begin
                        matrix_d[{k_q, 3'b000} +: 8] = bus.in_data;
                        k_d = k_q + 5'd1;
                        if (k_q == last_k_s) begin
                            wait_d  = WAIT_INIT;
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                S_WAIT: begin
                    if (wait_q == 8'd0) begin
                        result_d = bus.det_result;
                        state_d  = S_DONE;
                    end else begin
                        wait_d  = wait_q - 8'd1;
                        state_d = S_WAIT;
                    end
                end
                S_DONE: begin
                    if (bus.result_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Status flags are decoded from the next state so they leave flops.
        start_ready_d  = (state_d == S_IDLE);
        in_ready_d     = (state_d == S_LOAD);
        busy_d         = (state_d != S_IDLE);
        result_valid_d = (state_d == S_DONE);
    end

    // State, counters, matrix/result storage and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            k_q            <= 5'd0;
            wait_q         <= 8'd0;
            matrix_q       <= '0;
            size_q         <= 8'd0;
            result_q       <= 8'd0;
            error_q        <= 1'b0;
            result_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            wait_q         <= wait_d;
            matrix_q       <= matrix_d;
            size_q         <= size_d;
            result_q       <= result_d;
            error_q        <= error_d;
            result_valid_q <= result_valid_d;
            start_ready_q  <= start_ready_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.start_ready  = start_ready_q;
    assign bus.in_ready     = in_ready_q;
    assign bus.busy         = busy_q;
    assign bus.det_matrix   = matrix_q;
    assign bus.det_size     = size_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.error        = error_q;

endmodule

// File: tb/tb_det_sequencer.sv
// ---------------------------------------------------------------------------
// tb_det_sequencer
// Directed bench for det_sequencer (DET_LATENCY = 4). The determinant
// datapath is modelled by an integer Bareiss elimination on det_matrix;
// expected results are queued when a request is issued and compared when the
// result handshake happens.
// ---------------------------------------------------------------------------
module tb_det_sequencer;

    typedef struct {
        logic [7:0] res;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0 = 0;
    int   hs_base = 0;
    exp_t sb_q[$];
    logic [7:0] elems [25];

    det_sequencer_if bus();

    det_sequencer #(.DET_LATENCY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) hs_cnt <= hs_cnt + 1;
    end

    // Reference determinant unit: fraction-free elimination, low 8 bits.
    function automatic logic [7:0] det_model(input logic [199:0] mat, input logic [7:0] sz);
        longint m [5][5];
        longint prev, tmp, d;
        int n, sgn, piv;
        n = (sz > 8'd5) ? 5 : int'(sz);
        if (n < 1) return 8'h00;
        for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) m[i][j] = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                m[i][j] = longint'($signed(mat[(i*n+j)*8 +: 8]));
        prev = 1;
        sgn  = 1;
        for (int k = 0; k < n - 1; k++) begin
            if (m[k][k] == 0) begin
                piv = -1;
                for (int r = k + 1; r < n; r++) if (piv < 0 && m[r][k] != 0) piv = r;
                if (piv < 0) return 8'h00;
                for (int j = 0; j < n; j++) begin
                    tmp = m[k][j]; m[k][j] = m[piv][j]; m[piv][j] = tmp;
                end
                sgn = -sgn;
            end
            for (int i = k + 1; i < n; i++)
                for (int j = k + 1; j < n; j++)
                    m[i][j] = (m[k][k] * m[i][j] - m[i][k] * m[k][j]) / prev;
            prev = m[k][k];
        end
        d = m[n-1][n-1] * sgn;
        return d[7:0];
    endfunction

    assign bus.det_result = det_model(bus.det_matrix, bus.det_size);

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, 256'(obs), 256'(exp));
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check(tag, 256'(obs), 256'(exp));
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        check(tag, 256'(obs), 256'(exp));
    endtask

    task automatic check_idle(input string pfx);
        check1({pfx, "_start_ready"}, bus.start_ready, 1'b1);
        check1({pfx, "_in_ready"}, bus.in_ready, 1'b0);
        check1({pfx, "_busy"}, bus.busy, 1'b0);
        check1({pfx, "_result_valid"}, bus.result_valid, 1'b0);
        check1({pfx, "_error"}, bus.error, 1'b0);
        check8({pfx, "_result"}, bus.result, 8'h00);
        check8({pfx, "_det_size"}, bus.det_size, 8'h00);
        check({pfx, "_det_matrix"}, 256'(bus.det_matrix), 256'd0);
    endtask

    // Called at a negedge; returns at the negedge of cycle T+1.
    task automatic do_start(input logic [7:0] sz, input logic [7:0] exp_res,
                            input logic exp_err, input bit push);
        check1("start_ready_before_start", bus.start_ready, 1'b1);
        bus.start = 1'b1;
        bus.size  = sz;
        t0        = cyc;
        hs_base   = hs_cnt;
        if (push) sb_q.push_back('{exp_res, exp_err});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_elems(input int cnt, input int gap_at, input int gap_len, input int pulse_at);
        int guard;
        for (int i = 0; i < cnt; i++) begin
            if (i == 0) check1("in_ready_at_T1", bus.in_ready, 1'b1);
            if (i == gap_at) begin
                bus.in_valid = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = elems[i];
            bus.start    = (i == pulse_at);
            bus.size     = 8'd2;
            guard = 0;
            while (bus.in_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) check1("in_ready_timeout", bus.in_ready, 1'b1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic wait_result(input int exp_lat, input int hold);
        int   guard;
        exp_t e;
        guard = 0;
        while (bus.result_valid !== 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check1("result_valid_timeout", bus.result_valid, 1'b1);
        check_i("result_latency", cyc - t0, exp_lat);
        check_i("scoreboard_nonempty", (sb_q.size() > 0) ? 1 : 0, 1);
        e = '{8'h00, 1'b0};
        if (sb_q.size() > 0) e = sb_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check8("result_hold", bus.result, e.res);
            check1("result_valid_hold", bus.result_valid, 1'b1);
            @(negedge clk);
        end
        check8("result", bus.result, e.res);
        check1("error", bus.error, e.err);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check1("idle_after_handshake", bus.start_ready, 1'b1);
        check1("valid_drop_after_handshake", bus.result_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start        = 1'b0;
        bus.size         = 8'd0;
        bus.in_data      = 8'd0;
        bus.in_valid     = 1'b0;
        bus.abort        = 1'b0;
        bus.result_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 2x2 {3,4,2,5}, no stalls -> 7 at T+9
        elems[0] = 8'd3; elems[1] = 8'd4; elems[2] = 8'd2; elems[3] = 8'd5;
        do_start(8'd2, 8'h07, 1'b0, 1'b1);
        send_elems(4, -1, 0, -1);
        check8("t1_det_size", bus.det_size, 8'd2);
        wait_result(9, 0);
        check("t1_matrix", 256'(bus.det_matrix), 256'(32'h05020403));

        // 2x2 {1,2,3,4}, 3-cycle gap after 2nd byte, consumer stalls 10 cycles
        elems[0] = 8'd1; elems[1] = 8'd2; elems[2] = 8'd3; elems[3] = 8'd4;
        do_start(8'd2, 8'hFE, 1'b0, 1'b1);
        send_elems(4, 2, 3, -1);
        wait_result(12, 10);

        // 3x3 diag {2,3,4} -> 24, nine handshakes, upper bytes zero
        for (int i = 0; i < 25; i++) elems[i] = 8'd0;
        elems[0] = 8'd2; elems[4] = 8'd3; elems[8] = 8'd4;
        do_start(8'd3, 8'h18, 1'b0, 1'b1);
        send_elems(9, -1, 0, -1);
        check_i("t3_handshakes", hs_cnt - hs_base, 9);
        check("t3_upper_zero", 256'(bus.det_matrix[199:72]), 256'd0);
        wait_result(14, 0);

        // 5x5 identity with a stray start mid-load
        for (int i = 0; i < 25; i++) elems[i] = 8'd0;
        for (int i = 0; i < 5; i++) elems[i*6] = 8'd1;
        do_start(8'd5, 8'h01, 1'b0, 1'b1);
        send_elems(25, -1, 0, 5);
        check_i("t4_handshakes", hs_cnt - hs_base, 25);
        check8("t4_det_size", bus.det_size, 8'd5);
        wait_result(30, 0);

        // Abort after two elements, colliding with a third transfer
        elems[0] = 8'd3; elems[1] = 8'd4; elems[2] = 8'd2; elems[3] = 8'd5;
        do_start(8'd2, 8'h00, 1'b0, 1'b0);
        send_elems(2, -1, 0, -1);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        check_idle("abort");
        do_start(8'd2, 8'h07, 1'b0, 1'b1);
        send_elems(4, -1, 0, -1);
        wait_result(9, 0);

        // Out-of-range size 6
`ifdef DET_SEQ_SIZE_CHECK_EN
        do_start(8'd6, 8'h00, 1'b1, 1'b1);
        check1("sz6_no_in_ready", bus.in_ready, 1'b0);
        check8("sz6_det_size", bus.det_size, 8'd0);
        wait_result(1, 0);
        check_i("sz6_no_elems", hs_cnt - hs_base, 0);
`else
        for (int i = 0; i < 25; i++) elems[i] = 8'd0;
        for (int i = 0; i < 5; i++) elems[i*6] = 8'd1;
        elems[0] = 8'd2;
        do_start(8'd6, 8'h02, 1'b0, 1'b1);
        check8("sz6_clamped_size", bus.det_size, 8'd5);
        send_elems(25, -1, 0, -1);
        check_i("sz6_handshakes", hs_cnt - hs_base, 25);
        wait_result(30, 0);
`endif

        // Asynchronous reset during WAIT, then a start on the first edge after release
        elems[0] = 8'd3; elems[1] = 8'd4; elems[2] = 8'd2; elems[3] = 8'd5;
        do_start(8'd2, 8'h00, 1'b0, 1'b0);
        send_elems(4, -1, 0, -1);
        check1("wait_busy", bus.busy, 1'b1);
        check1("wait_in_ready_low", bus.in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_idle("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        do_start(8'd2, 8'h07, 1'b0, 1'b1);
        send_elems(4, -1, 0, -1);
        wait_result(9, 0);
        check_i("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
